// File: rtl/cp0_regs.sv
// Coprocessor-0 register file: MTC0/MFC0 access, exception entry/eret state update,
// redirect PC generation and the Count/Compare timer interrupt.
module cp0_regs (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [4:0]  raddr_i,
  input  logic [31:0] data_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] bad_addr_i,
  output logic [31:0] data_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] badvaddr_o,
  output logic        timer_int_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  localparam logic [4:0]  RegBadVAddr = 5'd8;
  localparam logic [4:0]  RegCount    = 5'd9;
  localparam logic [4:0]  RegCompare  = 5'd11;
  localparam logic [4:0]  RegStatus   = 5'd12;
  localparam logic [4:0]  RegCause    = 5'd13;
  localparam logic [4:0]  RegEpc      = 5'd14;

  localparam logic [31:0] StatusRst   = 32'h0040_0000;
  localparam logic [31:0] StatusWMask = 32'h0000_FF03;
  localparam logic [31:0] ExcVector   = 32'hBFC0_0380;
  localparam logic [31:0] ExcEret     = 32'h0000_000E;
  localparam logic [31:0] ExcInt      = 32'h0000_0001;
  localparam logic [31:0] ExcAdEL     = 32'h0000_0004;
  localparam logic [31:0] ExcAdES     = 32'h0000_0005;

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic        timer_int_q, timer_int_d;
  logic        phase_q, phase_d;

  logic exc_entry, exc_eret;

  assign exc_eret  = (excepttype_i == ExcEret);
  assign exc_entry = (excepttype_i != 32'd0) && !exc_eret;

  always_comb begin
    count_d     = count_q + 32'(phase_q);
    phase_d     = ~phase_q;
    compare_d   = compare_q;
    status_d    = status_q;
    cause_d     = cause_q;
    epc_d       = epc_q;
    badvaddr_d  = badvaddr_q;
    timer_int_d = timer_int_q | ((compare_q != 32'd0) && (count_q == compare_q));

    cause_d[15:10] = {int_i[5] | timer_int_q, int_i[4:0]};

    if (we_i) begin
      case (waddr_i)
        RegCount:   count_d = data_i;
        RegCompare: begin
          compare_d   = data_i;
          timer_int_d = 1'b0;
        end
        RegStatus:  status_d = (status_q & ~StatusWMask) | (data_i & StatusWMask);
        RegCause:   cause_d[9:8] = data_i[9:8];
        RegEpc:     epc_d = data_i;
        default:    ;
      endcase
    end

    // Exception fields override any MTC0 to the same fields in this cycle.
    if (exc_entry) begin
      if (!status_q[1]) begin
        epc_d       = is_in_delayslot_i ? current_inst_addr_i - 32'd4 : current_inst_addr_i;
        cause_d[31] = is_in_delayslot_i;
      end
      status_d[1]  = 1'b1;
      cause_d[6:2] = (excepttype_i == ExcInt) ? 5'd0 : excepttype_i[4:0];
      if ((excepttype_i == ExcAdEL) || (excepttype_i == ExcAdES)) begin
        badvaddr_d = bad_addr_i;
      end
    end else if (exc_eret) begin
      status_d[1] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= 32'd0;
      compare_q   <= 32'd0;
      status_q    <= StatusRst;
      cause_q     <= 32'd0;
      epc_q       <= 32'd0;
      badvaddr_q  <= 32'd0;
      timer_int_q <= 1'b0;
      phase_q     <= 1'b0;
    end else begin
      count_q     <= count_d;
      compare_q   <= compare_d;
      status_q    <= status_d;
      cause_q     <= cause_d;
      epc_q       <= epc_d;
      badvaddr_q  <= badvaddr_d;
      timer_int_q <= timer_int_d;
      phase_q     <= phase_d;
    end
  end

  always_comb begin
    data_o = 32'd0;
    case (raddr_i)
      RegBadVAddr: data_o = badvaddr_q;
      RegCount:    data_o = count_q;
      RegCompare:  data_o = compare_q;
      RegStatus:   data_o = status_q;
      RegCause:    data_o = cause_q;
      RegEpc:      data_o = epc_q;
      default:     data_o = 32'd0;
    endcase
  end

  always_comb begin
    flush_o  = (excepttype_i != 32'd0);
    new_pc_o = 32'd0;
    if (exc_eret) begin
      new_pc_o = epc_q;
    end else if (exc_entry) begin
      new_pc_o = ExcVector;
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign status_o    = status_q;
  assign cause_o     = cause_q;
  assign epc_o       = epc_q;
  assign badvaddr_o  = badvaddr_q;
  assign timer_int_o = timer_int_q;

endmodule

// File: tb/tb_cp0_regs.sv
// Self-checking bench for cp0_regs: directed scenarios plus randomized traffic
// checked against a field-level reference model.
module tb_cp0_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr, raddr;
  logic [31:0] wdata;
  logic [5:0]  intr;
  logic [31:0] exc, pc, badaddr;
  logic        ds;

  logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o, new_pc_o;
  logic        timer_int_o, flush_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cp0_regs dut (
    .clk                 (clk),
    .rst                 (rst),
    .we_i                (we),
    .waddr_i             (waddr),
    .raddr_i             (raddr),
    .data_i              (wdata),
    .int_i               (intr),
    .excepttype_i        (exc),
    .current_inst_addr_i (pc),
    .is_in_delayslot_i   (ds),
    .bad_addr_i          (badaddr),
    .data_o              (data_o),
    .count_o             (count_o),
    .compare_o           (compare_o),
    .status_o            (status_o),
    .cause_o             (cause_o),
    .epc_o               (epc_o),
    .badvaddr_o          (badvaddr_o),
    .timer_int_o         (timer_int_o),
    .flush_o             (flush_o),
    .new_pc_o            (new_pc_o)
  );

  // Reference model, kept as architectural fields.
  logic [31:0] m_count, m_compare, m_epc, m_bad;
  logic [7:0]  m_im;
  logic        m_exl, m_ie, m_bd, m_timer, m_phase;
  logic [1:0]  m_swip;
  logic [4:0]  m_code;
  logic [5:0]  m_hwip;

  function automatic logic [31:0] exp_status();
    return 32'h0040_0000 | {16'd0, m_im, 6'd0, m_exl, m_ie};
  endfunction

  function automatic logic [31:0] exp_cause();
    return {m_bd, 15'd0, m_hwip, m_swip, 1'b0, m_code, 2'b00};
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_bad;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return exp_status();
      5'd13:   return exp_cause();
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] exp_newpc();
    if (exc == 32'hE) return m_epc;
    if (exc != 32'd0) return 32'hBFC0_0380;
    return 32'd0;
  endfunction

  task automatic model_step();
    logic n_timer;
    logic old_exl;
    if (rst) begin
      m_count = 0; m_compare = 0; m_epc = 0; m_bad = 0; m_im = 0; m_exl = 0; m_ie = 0;
      m_bd = 0; m_timer = 0; m_phase = 0; m_swip = 0; m_code = 0; m_hwip = 0;
    end else begin
      old_exl = m_exl;
      n_timer = m_timer || (m_compare != 0 && m_count == m_compare);
      m_hwip  = {intr[5] | m_timer, intr[4:0]};
      if (m_phase) m_count = m_count + 1;
      m_phase = !m_phase;
      if (we) begin
        if (waddr == 9) m_count = wdata;
        if (waddr == 11) begin m_compare = wdata; n_timer = 0; end
        if (waddr == 12) begin m_im = wdata[15:8]; m_exl = wdata[1]; m_ie = wdata[0]; end
        if (waddr == 13) m_swip = wdata[9:8];
        if (waddr == 14) m_epc = wdata;
      end
      if (exc == 32'hE) begin
        m_exl = 0;
      end else if (exc != 0) begin
        if (!old_exl) begin
          m_epc = ds ? pc - 4 : pc;
          m_bd  = ds;
        end
        m_exl  = 1;
        m_code = (exc == 1) ? 5'd0 : exc[4:0];
        if (exc == 4 || exc == 5) m_bad = badaddr;
      end
      m_timer = n_timer;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; we = 0; waddr = 0; raddr = 0; wdata = 0; intr = 0;
    exc = 0; pc = 0; badaddr = 0; ds = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
    checks++; if (status_o !== 32'h0040_0000) begin errors++;
      $display("FAIL reset_status got %h want %h", status_o, 32'h0040_0000); end
    checks++; if ({count_o, compare_o, cause_o, epc_o, badvaddr_o} !== 160'd0) begin errors++;
      $display("FAIL reset_regs got %h %h %h %h %h want 0", count_o, compare_o, cause_o, epc_o,
               badvaddr_o); end
    checks++; if ({timer_int_o, flush_o, new_pc_o, data_o} !== 66'd0) begin errors++;
      $display("FAIL reset_misc got %b %b %h %h want 0", timer_int_o, flush_o, new_pc_o, data_o); end
    for (int i = 0; i < 10; i++) tick();
    checks++; if (count_o !== 32'd5) begin errors++;
      $display("FAIL count_rate got %0d want 5", count_o); end
  endtask

  task automatic test_write_masks();
    idle_inputs();
    we = 1; waddr = 12; wdata = 32'hFFFF_FFFF;
    tick();
    raddr = 12; we = 0; #1;
    checks++; if (data_o !== 32'h0040_FF03) begin errors++;
      $display("FAIL status_mask got %h want %h", data_o, 32'h0040_FF03); end
    we = 1; waddr = 13; wdata = 32'hFFFF_FFFF;
    tick();
    checks++; if (cause_o !== 32'h0000_0300) begin errors++;
      $display("FAIL cause_mask got %h want %h", cause_o, 32'h0000_0300); end
    waddr = 8; wdata = 32'hDEAD_BEEF;
    tick();
    checks++; if (badvaddr_o !== 32'd0) begin errors++;
      $display("FAIL badvaddr_ro got %h want 0", badvaddr_o); end
    waddr = 12; wdata = 32'd0;
    tick();
    we = 0; raddr = 5'd3; #1;
    checks++; if (data_o !== 32'd0) begin errors++;
      $display("FAIL unimpl_read got %h want 0", data_o); end
  endtask

  task automatic test_timer();
    logic [31:0] prev;
    bit rose;
    idle_inputs();
    we = 1; waddr = 11; wdata = 32'd20;
    tick();
    waddr = 9; wdata = 32'd0;
    tick();
    we = 0;
    rose = 0;
    prev = 0;
    for (int i = 0; i < 100 && !rose; i++) begin
      prev = count_o;
      tick();
      checks++; if (timer_int_o !== m_timer) begin errors++;
        $display("FAIL timer_track got %b want %b", timer_int_o, m_timer); end
      rose = (timer_int_o === 1'b1);
    end
    checks++; if (!rose) begin errors++;
      $display("FAIL timer_rise got %b want 1", timer_int_o); end
    checks++; if (prev !== 32'd20) begin errors++;
      $display("FAIL timer_rise_count got %0d want 20", prev); end
    checks++; if (cause_o[15] !== 1'b0) begin errors++;
      $display("FAIL timer_ip7_early got %b want 0", cause_o[15]); end
    tick();
    checks++; if (cause_o[15] !== 1'b1) begin errors++;
      $display("FAIL timer_ip7 got %b want 1", cause_o[15]); end
    we = 1; waddr = 11; wdata = 32'h0001_0000;
    tick();
    we = 0;
    checks++; if (timer_int_o !== 1'b0) begin errors++;
      $display("FAIL timer_clear got %b want 0", timer_int_o); end
  endtask

  task automatic test_exceptions();
    idle_inputs();
    exc = 32'h4; pc = 32'h8000_1004; ds = 1; badaddr = 32'h1235;
    #1;
    checks++; if (new_pc_o !== 32'hBFC0_0380 || flush_o !== 1'b1) begin errors++;
      $display("FAIL adel_redirect got %h/%b want bfc00380/1", new_pc_o, flush_o); end
    tick();
    checks++; if (epc_o !== 32'h8000_1000) begin errors++;
      $display("FAIL adel_epc got %h want 80001000", epc_o); end
    checks++; if (cause_o[31] !== 1'b1 || cause_o[6:2] !== 5'd4) begin errors++;
      $display("FAIL adel_cause got %h want BD=1 code=4", cause_o); end
    checks++; if (status_o[1] !== 1'b1 || badvaddr_o !== 32'h1235) begin errors++;
      $display("FAIL adel_exl_bad got %h/%h want EXL=1 bad=1235", status_o, badvaddr_o); end
    exc = 32'hC; pc = 32'h8000_2000; ds = 0;
    tick();
    checks++; if (epc_o !== 32'h8000_1000 || cause_o[6:2] !== 5'd12 || cause_o[31] !== 1'b1)
    begin errors++;
      $display("FAIL nested_ov got epc=%h cause=%h want 80001000 code=12 BD=1", epc_o, cause_o); end
    exc = 32'hE; #1;
    checks++; if (new_pc_o !== 32'h8000_1000) begin errors++;
      $display("FAIL eret_newpc got %h want 80001000", new_pc_o); end
    tick();
    checks++; if (status_o[1] !== 1'b0) begin errors++;
      $display("FAIL eret_exl got %b want 0", status_o[1]); end
    exc = 0; #1;
    checks++; if (flush_o !== 1'b0 || new_pc_o !== 32'd0) begin errors++;
      $display("FAIL no_exc got %b/%h want 0/0", flush_o, new_pc_o); end
  endtask

  task automatic test_simultaneous();
    idle_inputs();
    we = 1; waddr = 12; wdata = 32'h0000_FF01;
    tick();
    wdata = 32'd0; exc = 32'h8; pc = 32'h8000_3000;
    tick();
    idle_inputs();
    checks++; if (status_o !== 32'h0040_0002) begin errors++;
      $display("FAIL simul_status got %h want 00400002", status_o); end
    checks++; if (cause_o[6:2] !== 5'd8 || epc_o !== 32'h8000_3000) begin errors++;
      $display("FAIL simul_cause got code=%0d epc=%h want 8 80003000", cause_o[6:2], epc_o); end
    exc = 32'hE;
    tick();
    exc = 0;
  endtask

  task automatic test_random();
    logic [4:0]  addrs [8];
    logic [31:0] codes [9];
    int sel;
    addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3, 5'd0};
    codes = '{32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'hA, 32'hC, 32'hE, 32'hE};
    for (int i = 0; i < 600; i++) begin
      rst     = ($urandom_range(0, 199) == 0);
      we      = ($urandom_range(0, 2) == 0);
      waddr   = addrs[$urandom_range(0, 7)];
      raddr   = addrs[$urandom_range(0, 7)];
      wdata   = $urandom;
      if (waddr == 11 && $urandom_range(0, 1) == 1) wdata = m_count + $urandom_range(1, 6);
      intr    = 6'($urandom);
      sel     = $urandom_range(0, 19);
      exc     = (sel < 9) ? codes[sel] : 32'd0;
      pc      = $urandom & 32'hFFFF_FFFC;
      ds      = 1'($urandom);
      badaddr = $urandom;
      #1;
      checks++; if (data_o !== exp_read(raddr)) begin errors++;
        $display("FAIL rnd_read[%0d] r%0d got %h want %h", i, raddr, data_o, exp_read(raddr)); end
      checks++; if (flush_o !== (exc != 0) || new_pc_o !== exp_newpc()) begin errors++;
        $display("FAIL rnd_redirect[%0d] got %b/%h want %b/%h", i, flush_o, new_pc_o, exc != 0,
                 exp_newpc()); end
      tick();
      checks++; if (count_o !== m_count || compare_o !== m_compare) begin errors++;
        $display("FAIL rnd_timer_regs[%0d] got %h/%h want %h/%h", i, count_o, compare_o,
                 m_count, m_compare); end
      checks++; if (status_o !== exp_status()) begin errors++;
        $display("FAIL rnd_status[%0d] got %h want %h", i, status_o, exp_status()); end
      checks++; if (cause_o !== exp_cause()) begin errors++;
        $display("FAIL rnd_cause[%0d] got %h want %h", i, cause_o, exp_cause()); end
      checks++; if (epc_o !== m_epc || badvaddr_o !== m_bad) begin errors++;
        $display("FAIL rnd_epc_bad[%0d] got %h/%h want %h/%h", i, epc_o, badvaddr_o, m_epc,
                 m_bad); end
      checks++; if (timer_int_o !== m_timer) begin errors++;
        $display("FAIL rnd_timer_int[%0d] got %b want %b", i, timer_int_o, m_timer); end
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    rst = 1; we = 1; waddr = 9; wdata = 32'd123; exc = 32'h4; badaddr = 32'hFFFF; intr = 6'h3F;
    tick();
    idle_inputs();
    checks++; if (count_o !== 32'd0 || status_o !== 32'h0040_0000 || cause_o !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset got %h %h %h want 0 00400000 0", count_o, status_o, cause_o); end
    checks++; if (badvaddr_o !== 32'd0 || epc_o !== 32'd0 || timer_int_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset2 got %h %h %b want 0", badvaddr_o, epc_o, timer_int_o); end
  endtask

  initial begin
    test_reset();
    test_write_masks();
    test_timer();
    test_exceptions();
    test_simultaneous();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
